// File: rtl/pulse_voice_bank.sv
// pulse_voice_bank: NCH independent pulse-wave voices. Each voice runs from
// shadowed length/duty/amplitude so mid-period input changes never glitch a
// period. Per-voice samples are offset-binary around MID, and the mix is the
// saturated sum of all voices.
module pulse_voice_bank #(
  parameter int NCH    = 4,
  parameter int LEN_W  = 16,
  parameter int DUTY_W = 6,
  parameter int AMP_W  = 7,
  parameter int OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic [NCH*LEN_W-1:0]  wave_length,
  input  logic [NCH*DUTY_W-1:0] duty,
  input  logic [NCH*AMP_W-1:0]  amplitude,
  input  logic [NCH-1:0]        ch_en,
  input  logic [NCH-1:0]        retrig,
  output logic [NCH*OUT_W-1:0]  out,
  output logic [OUT_W-1:0]      mix,
  output logic [NCH-1:0]        cycle_start
);

  localparam int SUM_W = OUT_W + $clog2(NCH) + 1;
  localparam logic [OUT_W-1:0]        MID     = OUT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MID_S   = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MAX_S   = SUM_W'((1 << OUT_W) - 1);
  localparam logic [LEN_W-1:0]        LEN_ONE = LEN_W'(1);

  logic [LEN_W-1:0]        pos_q  [NCH];
  logic [LEN_W-1:0]        pos_d  [NCH];
  logic [LEN_W-1:0]        len_q  [NCH];
  logic [LEN_W-1:0]        len_d  [NCH];
  logic [DUTY_W-1:0]       duty_q [NCH];
  logic [DUTY_W-1:0]       duty_d [NCH];
  logic [AMP_W-1:0]        amp_q  [NCH];
  logic [AMP_W-1:0]        amp_d  [NCH];
  logic [NCH-1:0]          load;
  logic [NCH-1:0]          cs_q, cs_d;
  // Set by reset so the first clk after release restarts every enabled
  // voice as if retriggered (the shadow is all-zero until then).
  logic                    reload_q;
  logic [NCH*OUT_W-1:0]    out_q, out_d;
  logic [OUT_W-1:0]        mix_q, mix_d;
  logic [LEN_W+DUTY_W-1:0] prod   [NCH];
  logic [LEN_W-1:0]        high_s [NCH];
  logic signed [SUM_W-1:0] level  [NCH];
  logic signed [SUM_W-1:0] mix_acc;

  // Signed level of each voice from its shadow and current position.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      prod[i]   = {{DUTY_W{1'b0}}, len_q[i]} * {{LEN_W{1'b0}}, duty_q[i]};
      high_s[i] = LEN_W'(prod[i] >> DUTY_W);
      level[i]  = '0;
      if (ch_en[i] && (len_q[i] != '0)) begin
        if (pos_q[i] < high_s[i]) begin
          level[i] = SUM_W'(amp_q[i]);
        end else begin
          level[i] = -SUM_W'(amp_q[i]);
        end
      end
    end
  end

  // Per-voice samples and the saturated mix, both registered next clk.
  always_comb begin
    mix_acc = MID_S;
    out_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      out_d[i*OUT_W +: OUT_W] = OUT_W'(MID_S + level[i]);
      mix_acc = mix_acc + level[i];
    end
    if (mix_acc < 0) begin
      mix_d = '0;
    end else if (mix_acc > MAX_S) begin
      mix_d = '1;
    end else begin
      mix_d = mix_acc[OUT_W-1:0];
    end
  end

  // Position advance, period wrap and shadow load per voice; retrig wins
  // over a simultaneous tick, and a disabled voice parks at pos 0 while
  // tracking its inputs.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pos_d[i] = pos_q[i];
      cs_d[i]  = 1'b0;
      load[i]  = 1'b0;
      if (!ch_en[i]) begin
        pos_d[i] = '0;
        load[i]  = 1'b1;
      end else if (retrig[i] || reload_q) begin
        pos_d[i] = '0;
        load[i]  = 1'b1;
        cs_d[i]  = 1'b1;
      end else if (sample_tick && (len_q[i] != '0)) begin
        if (pos_q[i] >= len_q[i] - LEN_ONE) begin
          pos_d[i] = '0;
          load[i]  = 1'b1;
          cs_d[i]  = 1'b1;
        end else begin
          pos_d[i] = pos_q[i] + LEN_ONE;
        end
      end
      len_d[i]  = load[i] ? wave_length[i*LEN_W +: LEN_W] : len_q[i];
      duty_d[i] = load[i] ? duty[i*DUTY_W +: DUTY_W]      : duty_q[i];
      amp_d[i]  = load[i] ? amplitude[i*AMP_W +: AMP_W]   : amp_q[i];
    end
  end

  // State registers with synchronous reset to silence at MID.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        pos_q[i]  <= '0;
        len_q[i]  <= '0;
        duty_q[i] <= '0;
        amp_q[i]  <= '0;
      end
      cs_q     <= '0;
      reload_q <= 1'b1;
      out_q    <= {NCH{MID}};
      mix_q    <= MID;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        pos_q[i]  <= pos_d[i];
        len_q[i]  <= len_d[i];
        duty_q[i] <= duty_d[i];
        amp_q[i]  <= amp_d[i];
      end
      cs_q     <= cs_d;
      reload_q <= 1'b0;
      out_q    <= out_d;
      mix_q    <= mix_d;
    end
  end

  assign out         = out_q;
  assign mix         = mix_q;
  assign cycle_start = cs_q;

endmodule

// File: doc/pulse_voice_bank.md
PULSE_VOICE_BANK -- requirements
Module: pulse_voice_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent pulse channels.
REQ-002 SHALL have parameter LEN_W, default 16, width of the per-channel period in samples.
REQ-003 SHALL have parameter DUTY_W, default 6, width of the duty fraction; duty is in units of 1/2^DUTY_W.
REQ-004 SHALL have parameter AMP_W, default 7, width of the per-channel amplitude.
REQ-005 SHALL have parameter OUT_W, default 8, output sample width; MID = 2^(OUT_W-1)-1 (127 at default).
REQ-006 SHALL have port clk, input, 1, the single system clock.
REQ-007 SHALL have port rst, input, 1, reset, synchronous to clk and active-high.
REQ-008 SHALL have port sample_tick, input, 1, one-clk strobe at the sample rate (20 kHz).
REQ-009 SHALL have port wave_length, input, NCH*LEN_W, per-channel period in samples; channel i occupies bits [i*LEN_W +: LEN_W].
REQ-010 SHALL have port duty, input, NCH*DUTY_W, per-channel duty, packed the same way.
REQ-011 SHALL have port amplitude, input, NCH*AMP_W, per-channel amplitude, packed the same way.
REQ-012 SHALL have port ch_en, input, NCH, per-channel enable.
REQ-013 SHALL have port retrig, input, NCH, per-channel one-clk phase-restart strobe.
REQ-014 SHALL have port out, output, NCH*OUT_W, registered per-channel samples, packed the same way.
REQ-015 SHALL have port mix, output, OUT_W, registered saturated sum of all channels.
REQ-016 SHALL have port cycle_start, output, NCH, one-clk pulse when a channel's period restarts.

Function
REQ-017 Each channel SHALL hold shadow registers len_s, duty_s and amp_s; only the shadow values drive generation.
REQ-018 Shadow SHALL load from the inputs on period wrap, on retrig, and on every clk while the channel is disabled; input changes mid-period SHALL NOT alter the current period (glitch-free update).
REQ-019 high_s SHALL be (len_s*duty_s)>>DUTY_W, computed at LEN_W+DUTY_W width then truncated to LEN_W; low phase length SHALL be len_s-high_s.
REQ-020 Each channel SHALL hold a position counter pos[LEN_W-1:0].
REQ-021 On a clk with sample_tick=1, ch_en=1 and no retrig, pos SHALL become 0 if pos>=len_s-1, and pos+1 otherwise; the wrap SHALL load the shadow and pulse cycle_start[i] for exactly that clk.
REQ-022 retrig[i]=1 SHALL set pos to 0, load the shadow and pulse cycle_start[i]; it SHALL take priority over a simultaneous sample_tick, so pos is 0 (not 1) afterwards.
REQ-023 Channel level SHALL be +amp_s when ch_en=1, len_s!=0 and pos<high_s; it SHALL be -amp_s when ch_en=1, len_s!=0 and pos>=high_s; otherwise it SHALL be 0.
REQ-024 Consequences of REQ-023: duty 0 gives constant low; len_s 0 gives silence at MID with pos held at 0 and no cycle_start.
REQ-025 out[i] SHALL be MID+level, registered one clk after the pos/shadow update, so out lags a tick by 2 clk.
REQ-026 out[i] SHALL NOT exceed its range at default parameters (MID+127=254, MID-127=0).
REQ-027 mix SHALL be MID plus the signed sum of all channel levels, evaluated at a width of OUT_W+clog2(NCH)+1 bits.
REQ-028 mix SHALL saturate to 0 and to 2^OUT_W-1, and SHALL be registered in the same clk as out.
REQ-029 ch_en[i]=0 SHALL hold pos at 0, force level 0 and suppress cycle_start; on re-enable, the period SHALL start at pos 0 in the high phase.
REQ-030 The period in samples SHALL be exactly len_s; the high phase SHALL be exactly high_s samples.

Reset
REQ-031 rst=1 at a clk edge SHALL clear every pos and every shadow register to 0.
REQ-032 rst=1 SHALL set every out[i] to MID, set mix to MID and clear cycle_start to 0.
REQ-033 rst SHALL override sample_tick, retrig and ch_en.
REQ-034 rst asserted mid-period SHALL abandon the current period; after release, generation SHALL restart from pos 0, with the shadow loaded on the next clk (channel enabled via retrig semantics, or disabled via continuous load).

Verification
REQ-035 Bench SHALL drive ch0 len=8, duty=32, amp=100, ch_en=1, tick every clk: out0 = 227 for 4 ticks, then 27 for 4 ticks, repeating; cycle_start0 every 8 ticks.
REQ-036 Bench SHALL change len 8->12 at pos=3: the current period completes at 8 samples, the next period is 12 with high_s=6.
REQ-037 Bench SHALL run all 4 channels with amp=100 in phase, all high: mix saturates at 255; all low: mix saturates at 0; two high and two low: mix = 127.
REQ-038 Bench SHALL assert retrig0 together with sample_tick at pos=5: next pos=0, cycle_start0=1, out0 high.
REQ-039 Bench SHALL cover len=0 or duty=0: len=0 gives out0=127 with no cycle_start; duty=0, len=4, amp=50 gives out0=77 constantly with cycle_start every 4 ticks.
REQ-040 Bench SHALL assert rst for 1 clk mid-period: next clk out=127, mix=127 and all pos=0; generation then resumes from a period start.
